// File: rtl/fifo_pkg.sv
// Shared types and default parameters for the FIFO write-port arbiter.
// Included first so the interface, picker and top can all import it.
package fifo_pkg;

   localparam int NUM_REQ_DEF   = 4;
   localparam int WIDTH_DEF     = 8;
   localparam int DEPTH_DEF     = 8;
   localparam int MAX_BURST_DEF = 4;

   typedef logic [$clog2(DEPTH_DEF+1)-1:0] credit_t;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write arbiter.
// The master modport is the arbiter's view; the slave modport is the producers' and FIFO's view.
interface fifo_wr_arbiter_if
   import fifo_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int WIDTH   = WIDTH_DEF,
   parameter int DEPTH   = DEPTH_DEF
);

   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ*WIDTH-1:0]   req_data;
   logic [NUM_REQ-1:0]         gnt;
   logic                       w_en;
   logic [WIDTH-1:0]           data_in;
   logic                       r_en;
   logic                       empty;
   logic                       full;
   logic [$clog2(DEPTH+1)-1:0] credits;
   logic                       overflow_err;

   modport master (
      input  req, req_data, r_en, empty, full,
      output gnt, w_en, data_in, credits, overflow_err
   );

   modport slave (
      output req, req_data, r_en, empty, full,
      input  gnt, w_en, data_in, credits, overflow_err
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: returns the first set request at or after ptr, wrapping modulo N.
// The result is purely combinational.
module rr_pick
   import fifo_pkg::*;
#(
   parameter  int N  = NUM_REQ_DEF,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);

   int j;

   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      j      = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!any && req[j]) begin
            any       = 1'b1;
            onehot[j] = 1'b1;
            idx       = IW'(j);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among NUM_REQ producers.
// A local credit count of free FIFO slots guarantees that no write lands on a full FIFO.
module fifo_wr_arbiter
   import fifo_pkg::*;
#(
   parameter int NUM_REQ   = NUM_REQ_DEF,
   parameter int WIDTH     = WIDTH_DEF,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input logic               clk,
   input logic               rst_n,
   fifo_wr_arbiter_if.master bus
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST+1);
   localparam int CW = $clog2(DEPTH+1);

   arb_state_e         state;
   logic [IW-1:0]      owner;
   logic [IW-1:0]      rr_ptr;
   logic [BW-1:0]      burst_cnt;
   logic [CW-1:0]      credits_q;
   logic [CW-1:0]      credits_next;
   logic               w_en_q;
   logic [WIDTH-1:0]   data_q;
   logic               overflow_q;

   logic [IW-1:0]      owner_next;
   logic [IW-1:0]      pick_ptr;
   logic [IW-1:0]      pick_idx;
   logic [IW-1:0]      grant_idx;
   logic [NUM_REQ-1:0] pick_onehot;
   logic [NUM_REQ-1:0] gnt_c;
   logic               pick_any;
   logic               have_credit;
   logic               keep_owner;
   logic               hold_owner;
   logic               leave_owner;
   logic               pick_grant;
   logic               grant_any;
   logic               rd_valid;

   assign owner_next  = (owner == IW'(NUM_REQ-1)) ? '0 : owner + IW'(1);
   assign have_credit = (credits_q != '0);
   assign rd_valid    = bus.r_en && !bus.empty;

   // A starved owner keeps the port (hold) so nobody can slip in while it waits for credit.
   assign keep_owner  = (state == OWN) && bus.req[owner] && have_credit && (burst_cnt < BW'(MAX_BURST));
   assign hold_owner  = (state == OWN) && bus.req[owner] && !have_credit;
   assign leave_owner = (state == OWN) && !keep_owner && !hold_owner;
   assign pick_ptr    = leave_owner ? owner_next : rr_ptr;
   assign pick_grant  = ((state == IDLE) || leave_owner) && pick_any && have_credit;

   rr_pick #(.N(NUM_REQ)) u_pick (
      .req    (bus.req),
      .ptr    (pick_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      gnt_c = '0;
      if (keep_owner) begin
         gnt_c[owner] = 1'b1;
      end else if (pick_grant) begin
         gnt_c = pick_onehot;
      end
      if (!rst_n) begin
         gnt_c = '0;
      end
   end

   assign grant_any = |gnt_c;
   assign grant_idx = keep_owner ? owner : pick_idx;

   always_comb begin
      credits_next = credits_q;
      if (grant_any && !rd_valid) begin
         credits_next = credits_q - CW'(1);
      end else if (!grant_any && rd_valid && (credits_q != CW'(DEPTH))) begin
         credits_next = credits_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= '0;
         rr_ptr     <= '0;
         burst_cnt  <= '0;
         credits_q  <= CW'(DEPTH);
         w_en_q     <= 1'b0;
         data_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         credits_q  <= credits_next;
         w_en_q     <= grant_any;
         overflow_q <= overflow_q | (w_en_q & bus.full);
         if (grant_any) begin
            data_q <= bus.req_data[grant_idx*WIDTH +: WIDTH];
         end
         case (state)
            IDLE: begin
               if (pick_grant) begin
                  owner     <= pick_idx;
                  burst_cnt <= BW'(1);
                  state     <= OWN;
               end
            end
            OWN: begin
               if (keep_owner) begin
                  burst_cnt <= burst_cnt + BW'(1);
               end else if (leave_owner) begin
                  rr_ptr <= owner_next;
                  if (pick_grant) begin
                     owner     <= pick_idx;
                     burst_cnt <= BW'(1);
                  end else begin
                     burst_cnt <= '0;
                     state     <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.gnt          = gnt_c;
   assign bus.w_en         = w_en_q;
   assign bus.data_in      = data_q;
   assign bus.credits      = credits_q;
   assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the arbitration rules.
module tb_fifo_wr_arbiter;
   import fifo_pkg::*;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int D  = 8;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D)) bus ();

   fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D), .MAX_BURST(MB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state: ownership, burst length, pointer, credits, expected registered outputs.
   bit         m_own;
   int         m_owner;
   int         m_burst;
   int         m_ptr;
   credit_t    m_cred;
   bit         exp_w_en;
   logic [W-1:0] exp_data;
   bit         exp_ovf;
   int         occ;
   bit         force_full;
   logic [W-1:0] next_word = 8'h10;
   logic [W-1:0] pq [N][$];
   int         grant_log [$];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic int firstFrom(input int p, input logic [N-1:0] r);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic arbStep(input logic [N-1:0] r, output int gi);
      gi = -1;
      if (!m_own) begin
         if (m_cred > 0) gi = firstFrom(m_ptr, r);
         if (gi >= 0) begin
            m_own = 1'b1; m_owner = gi; m_burst = 1;
         end
      end else if (r[m_owner] && m_cred > 0 && m_burst < MB) begin
         gi = m_owner;
         m_burst++;
      end else if (r[m_owner] && m_cred == 0) begin
         gi = -1;
      end else begin
         m_ptr = (m_owner + 1) % N;
         if (m_cred > 0) gi = firstFrom(m_ptr, r);
         if (gi >= 0) begin
            m_owner = gi; m_burst = 1;
         end else begin
            m_own = 1'b0;
         end
      end
   endtask

   task automatic modelReset();
      m_own = 1'b0; m_owner = 0; m_burst = 0; m_ptr = 0; m_cred = credit_t'(D);
      exp_w_en = 1'b0; exp_data = '0; exp_ovf = 1'b0; occ = 0;
   endtask

   task automatic pushWords(input int p, input int n);
      for (int k = 0; k < n; k++) begin
         pq[p].push_back(next_word);
         next_word = next_word + 8'd7;
      end
   endtask

   // One clock cycle: drive at the falling edge, check after settling, advance the model, end on the rising edge.
   task automatic applyStimulus(input bit rd, input bit force_empty);
      logic [N-1:0]   r;
      logic [N*W-1:0] d;
      logic [N-1:0]   exp_gnt;
      bit             emp, ful, rdv;
      int             gi;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         r[i] = (pq[i].size() != 0);
         d[i*W +: W] = r[i] ? pq[i][0] : '0;
      end
      emp = force_empty || (occ == 0);
      ful = force_full || (occ >= D);
      bus.req = r; bus.req_data = d; bus.r_en = rd; bus.empty = emp; bus.full = ful;
      #1;
      arbStep(r, gi);
      exp_gnt = '0;
      if (gi >= 0) exp_gnt[gi] = 1'b1;
      checkOutput("gnt", 32'(bus.gnt), 32'(exp_gnt));
      checkOutput("w_en", 32'(bus.w_en), 32'(exp_w_en));
      checkOutput("data_in", 32'(bus.data_in), 32'(exp_data));
      checkOutput("credits", 32'(bus.credits), 32'(m_cred));
      checkOutput("overflow_err", 32'(bus.overflow_err), 32'(exp_ovf));
      rdv = rd && !emp;
      exp_ovf = exp_ovf | (exp_w_en && ful);
      occ = occ + (exp_w_en ? 1 : 0) - (rdv ? 1 : 0);
      if (occ > D) occ = D;
      if (occ < 0) occ = 0;
      m_cred = credit_t'(int'(m_cred) - ((gi >= 0) ? 1 : 0) + (rdv ? 1 : 0));
      if (m_cred > D) m_cred = credit_t'(D);
      exp_w_en = (gi >= 0);
      if (gi >= 0) begin
         exp_data = pq[gi].pop_front();
         grant_log.push_back(gi);
      end
      @(posedge clk);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req = '0; bus.req_data = '0; bus.r_en = 1'b0; bus.empty = 1'b1; bus.full = 1'b0;
      force_full = 1'b0;
      #1;
      checkOutput("rst_gnt", 32'(bus.gnt), 32'd0);
      checkOutput("rst_w_en", 32'(bus.w_en), 32'd0);
      checkOutput("rst_data_in", 32'(bus.data_in), 32'd0);
      checkOutput("rst_credits", 32'(bus.credits), 32'(D));
      checkOutput("rst_overflow", 32'(bus.overflow_err), 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      modelReset();
      for (int i = 0; i < N; i++) pq[i].delete();
      grant_log.delete();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      force_full = 1'b0;
      bus.req = '0; bus.req_data = '0; bus.r_en = 1'b0; bus.empty = 1'b1; bus.full = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);

      $display("[TB] reset and idle");
      doReset();
      repeat (3) applyStimulus(1'b0, 1'b0);

      $display("[TB] single producer");
      doReset();
      pushWords(0, 3);
      repeat (6) applyStimulus(1'b0, 1'b0);
      #1;
      checkOutput("t2_grants", 32'(grant_log.size()), 32'd3);
      checkOutput("t2_credits", 32'(bus.credits), 32'd5);

      $display("[TB] fairness");
      doReset();
      for (int i = 0; i < N; i++) pushWords(i, 5);
      repeat (17) applyStimulus(1'b1, 1'b0);
      for (int k = 0; k < 17; k++) begin
         checkOutput($sformatf("t3_grant%0d", k),
                     (k < grant_log.size()) ? 32'(grant_log[k]) : 32'hFFFF,
                     32'((k / 4) % N));
      end

      $display("[TB] back-pressure");
      doReset();
      pushWords(2, 12);
      repeat (10) applyStimulus(1'b0, 1'b0);
      #1;
      checkOutput("t4_credits", 32'(bus.credits), 32'd0);
      checkOutput("t4_grants", 32'(grant_log.size()), 32'd8);
      applyStimulus(1'b1, 1'b0);
      repeat (2) applyStimulus(1'b0, 1'b0);
      #1;
      checkOutput("t4_one_more", 32'(grant_log.size()), 32'd9);
      checkOutput("t4_overflow", 32'(bus.overflow_err), 32'd0);

      $display("[TB] simultaneous grant and read");
      doReset();
      pushWords(1, 6);
      repeat (5) applyStimulus(1'b0, 1'b0);
      #1;
      checkOutput("t5_cred_pre", 32'(bus.credits), 32'd3);
      applyStimulus(1'b1, 1'b0);
      #1;
      checkOutput("t5_cred_sim", 32'(bus.credits), 32'd3);
      applyStimulus(1'b1, 1'b1);
      #1;
      checkOutput("t5_cred_empty", 32'(bus.credits), 32'd3);

      $display("[TB] overflow flag");
      pushWords(3, 1);
      applyStimulus(1'b0, 1'b0);
      force_full = 1'b1;
      applyStimulus(1'b0, 1'b0);
      force_full = 1'b0;
      applyStimulus(1'b0, 1'b0);
      #1;
      checkOutput("ovf_sticky", 32'(bus.overflow_err), 32'd1);

      $display("[TB] reset mid-burst");
      doReset();
      for (int i = 0; i < N; i++) pushWords(i, 3);
      repeat (2) applyStimulus(1'b0, 1'b0);
      #1;
      checkOutput("t6_w_en_pre", 32'(bus.w_en), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("t6_w_en_drop", 32'(bus.w_en), 32'd0);
      checkOutput("t6_gnt_drop", 32'(bus.gnt), 32'd0);
      checkOutput("t6_credits", 32'(bus.credits), 32'(D));
      rst_n = 1'b1;
      modelReset();
      grant_log.delete();
      repeat (2) applyStimulus(1'b0, 1'b0);
      checkOutput("t6_restart", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFF, 32'd0);

      $display("[TB] random traffic");
      doReset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (pq[i].size() < 6 && $urandom_range(0, 3) == 0) pushWords(i, $urandom_range(1, 3));
         end
         applyStimulus(($urandom_range(0, 2) != 0), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
